// File: rtl/pwm_spi_tx_pkg.sv
// pwm_spi_tx_pkg: shared constants for the PWM-value serial link.
// Holds FSM encodings, default sizes and a width helper.
package pwm_spi_tx_pkg;

    localparam int DEF_CLK_DIV = 2;
    localparam int DEF_DATA_W  = 8;
    localparam int DEF_GAP     = 4;

    localparam logic [2:0] ST_FLUSH = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_TRAIL = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    // Counter width for values 0..n-1, never narrower than 1 bit.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_spi_tx_tick_gen.sv
// spi_tick_gen: divides clk into spi_clk half-period ticks.
// Ports: clk, clr (sync clear), en (count enable), tick (1-cycle pulse).
module spi_tick_gen
    import pwm_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = cw(CLK_DIV + 1);

    logic [W-1:0] div_cnt;

    assign tick = en & (div_cnt == W'(CLK_DIV - 1));

    // Held at zero while disabled, so every enabled run starts
    // a fresh half-period.
    always_ff @(posedge clk) begin
        if (clr || !en || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_spi_tx.sv
// pwm_spi_tx: byte-to-3-wire serial initiator for the PWM receiver.
// Ports: clk, rst, tx_valid/tx_data/tx_ready, spi_clk/en/data, busy, done.
module pwm_spi_tx
    import pwm_spi_tx_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int GAP_CYCLES = DEF_GAP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              spi_clk,
    output logic              spi_en,
    output logic              spi_data,
    output logic              busy,
    output logic              done
);

    localparam int BW = cw(DATA_W);
    localparam int GW = cw(GAP_CYCLES);

    logic [2:0]        state;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic [GW-1:0]     gap_cnt;
    logic              tick;
    logic              tick_en;
    logic              accept;
    logic              last_bit;

    assign tx_ready = (state == ST_IDLE) & ~rst;
    assign accept   = tx_valid & tx_ready;
    assign busy     = (state == ST_SHIFT) |
                      (state == ST_TRAIL) |
                      (state == ST_GAP);
    assign tick_en  = (state == ST_FLUSH) |
                      (state == ST_SHIFT) |
                      (state == ST_TRAIL);
    assign last_bit = (bit_cnt == BW'(DATA_W - 1));

    spi_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .clr  (rst),
        .en   (tick_en),
        .tick (tick)
    );

    // spi_clk toggles on every tick while clocking; a tick seen
    // with spi_clk high is a falling edge, where data may change.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_FLUSH;
            spi_clk  <= 1'b0;
            spi_en   <= 1'b0;
            spi_data <= 1'b0;
            done     <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_FLUSH: begin
                    if (tick) begin
                        spi_clk <= ~spi_clk;
                        if (spi_clk) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        // shreg keeps the bits still to be sent.
                        shreg    <= tx_data >> 1;
                        bit_cnt  <= '0;
                        spi_en   <= 1'b1;
                        spi_data <= tx_data[0];
                        spi_clk  <= 1'b0;
                        state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        spi_clk <= ~spi_clk;
                        if (spi_clk) begin
                            if (last_bit) begin
                                spi_en   <= 1'b0;
                                spi_data <= 1'b0;
                                state    <= ST_TRAIL;
                            end else begin
                                bit_cnt  <= bit_cnt + 1'b1;
                                spi_data <= shreg[0];
                                shreg    <= shreg >> 1;
                            end
                        end
                    end
                end
                ST_TRAIL: begin
                    if (tick) begin
                        spi_clk <= ~spi_clk;
                        if (spi_clk) begin
                            done    <= 1'b1;
                            gap_cnt <= '0;
                            if (GAP_CYCLES == 0) begin
                                state <= ST_IDLE;
                            end else begin
                                state <= ST_GAP;
                            end
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_FLUSH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_spi_tx.sv
// tb_pwm_spi_tx: directed bench for pwm_spi_tx.
// Two instances: D=2/GAP=3 (with receiver model) and D=1/GAP=0.
module tb_pwm_spi_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tx_valid_a, tx_ready_a;
    logic [7:0] tx_data_a;
    logic       spi_clk_a, spi_en_a, spi_data_a;
    logic       busy_a, done_a;
    logic       tx_valid_b, tx_ready_b;
    logic [7:0] tx_data_b;
    logic       spi_clk_b, spi_en_b, spi_data_b;
    logic       busy_b, done_b;

    pwm_spi_tx #(
        .CLK_DIV    (2),
        .DATA_W     (8),
        .GAP_CYCLES (3)
    ) u_a (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid_a),
        .tx_data  (tx_data_a),
        .tx_ready (tx_ready_a),
        .spi_clk  (spi_clk_a),
        .spi_en   (spi_en_a),
        .spi_data (spi_data_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    pwm_spi_tx #(
        .CLK_DIV    (1),
        .DATA_W     (8),
        .GAP_CYCLES (0)
    ) u_b (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid_b),
        .tx_data  (tx_data_b),
        .tx_ready (tx_ready_b),
        .spi_clk  (spi_clk_b),
        .spi_en   (spi_en_b),
        .spi_data (spi_data_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic rise_en  [0:15];
    logic rise_dat [0:15];
    int   nrise = 0;

    always @(posedge spi_clk_a) begin
        if (nrise < 16) begin
            rise_en[nrise]  = spi_en_a;
            rise_dat[nrise] = spi_data_a;
        end
        nrise++;
    end

    logic [7:0] rx_sh   = 8'h00;
    logic [7:0] rx_duty = 8'h00;
    int         rx_idx  = 0;

    always @(posedge spi_clk_a) begin
        if (spi_en_a) begin
            rx_sh[rx_idx[2:0]] = spi_data_a;
            rx_idx++;
        end else begin
            rx_duty = rx_sh;
            rx_idx  = 0;
        end
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    function automatic logic [7:0] cap_byte();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = rise_dat[i];
        return r;
    endfunction

    function automatic logic [7:0] cap_en();
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = rise_en[i];
        return r;
    endfunction

    // Called at a negedge; returns at the negedge where
    // tx_ready_a is seen again. Cycle 1 = first cycle after accept.
    task automatic frame_a(input logic [7:0] b,
                           input bit hold,
                           input logic [7:0] nxt,
                           input int poke,
                           output int done_c,
                           output int rdy_c);
        int n;
        int c;
        n = 0;
        done_c = 0;
        rdy_c = 0;
        while (!tx_ready_a && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!tx_ready_a) chk("rdy_wait", 0, 1);
        nrise = 0;
        tx_valid_a = 1'b1;
        tx_data_a  = b;
        @(posedge clk);
        @(negedge clk);
        c = 1;
        if (!hold) tx_valid_a = 1'b0;
        else tx_data_a = nxt;
        while (c < 200) begin
            if (poke > 0 && c == poke) begin
                tx_valid_a = 1'b1;
                tx_data_a  = 8'hFF;
            end
            if (poke > 0 && c == poke + 1) tx_valid_a = 1'b0;
            if (done_a && done_c == 0) done_c = c;
            if (tx_ready_a) begin
                rdy_c = c;
                break;
            end
            @(negedge clk);
            c++;
        end
    endtask

    initial begin
        int dc, rc, c, bad;
        logic prev;

        rst = 1'b1;
        tx_valid_a = 1'b0;
        tx_data_a  = 8'h00;
        tx_valid_b = 1'b0;
        tx_data_b  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_a", {spi_clk_a, spi_en_a, spi_data_a,
                      busy_a, done_a, tx_ready_a}, 0);
        chk("rst_b", {spi_clk_b, spi_en_b, spi_data_b,
                      busy_b, done_b, tx_ready_b}, 0);
        rst = 1'b0;
        nrise = 0;
        c = 0;
        while (!tx_ready_a && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("flush_rdy", c, 4);
        chk("flush_rise", nrise, 1);
        chk("flush_en", rise_en[0], 0);

        // A5: bits, enables, trailing pulse, timing
        frame_a(8'hA5, 1'b0, 8'h00, 0, dc, rc);
        chk("a5_bits", cap_byte(), 8'hA5);
        chk("a5_en", cap_en(), 8'hFF);
        chk("a5_trail_en", rise_en[8], 0);
        chk("a5_nrise", nrise, 9);
        chk("a5_done", dc, 37);
        chk("a5_duty", rx_duty, 8'hA5);

        // back-to-back with tx_valid held high
        frame_a(8'h01, 1'b1, 8'h80, 0, dc, rc);
        chk("h01_bits", cap_byte(), 8'h01);
        chk("h01_rdy", rc, 40);
        frame_a(8'h80, 1'b0, 8'h00, 0, dc, rc);
        chk("h80_bits", cap_byte(), 8'h80);
        chk("h80_duty", rx_duty, 8'h80);

        // tx_valid pulse mid-frame is ignored
        frame_a(8'h96, 1'b0, 8'h00, 10, dc, rc);
        chk("poke_bits", cap_byte(), 8'h96);
        chk("poke_done", dc, 37);
        repeat (60) @(negedge clk);
        chk("poke_nrise", nrise, 9);
        chk("poke_busy", busy_a, 0);

        // reset during bit 3
        nrise = 0;
        tx_valid_a = 1'b1;
        tx_data_a  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        tx_valid_a = 1'b0;
        c = 0;
        while (nrise < 4 && c < 100) begin
            @(negedge clk);
            c++;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst", {spi_clk_a, spi_en_a, spi_data_a,
                        busy_a, done_a, tx_ready_a}, 0);
        rst = 1'b0;
        nrise = 0;
        c = 0;
        while (!tx_ready_a && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("mid_flush", c, 4);
        chk("mid_rise", nrise, 1);
        chk("mid_en", rise_en[0], 0);
        chk("mid_idx", rx_idx, 0);
        frame_a(8'h3C, 1'b0, 8'h00, 0, dc, rc);
        chk("mid_3c", cap_byte(), 8'h3C);
        chk("mid_duty", rx_duty, 8'h3C);

        // receiver model across patterns
        frame_a(8'h00, 1'b0, 8'h00, 0, dc, rc);
        chk("duty_00", rx_duty, 8'h00);
        frame_a(8'hFF, 1'b0, 8'h00, 0, dc, rc);
        chk("duty_ff", rx_duty, 8'hFF);
        frame_a(8'h3C, 1'b0, 8'h00, 0, dc, rc);
        chk("duty_3c", rx_duty, 8'h3C);

        // D=1, GAP=0 instance
        c = 0;
        while (!tx_ready_b && c < 50) begin
            @(negedge clk);
            c++;
        end
        tx_valid_b = 1'b1;
        tx_data_b  = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        tx_valid_b = 1'b0;
        c = 1;
        dc = 0;
        rc = 0;
        bad = 0;
        chk("b_clk1", spi_clk_b, 0);
        prev = spi_clk_b;
        while (c < 100) begin
            if (c >= 2 && c <= 18 && spi_clk_b == prev) bad++;
            prev = spi_clk_b;
            if (done_b && dc == 0) dc = c;
            if (tx_ready_b) begin
                rc = c;
                break;
            end
            @(negedge clk);
            c++;
        end
        chk("b_toggle", bad, 0);
        chk("b_done", dc, 19);
        chk("b_rdy", rc, 19);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
